// File: rtl/paper_sequencer.sv
// Micro-sequencer that fetches INC/DEC/JNO/STP instructions and issues them to an execution unit.
// Latency: JNO takes 2 cycles; INC/DEC take 3 or more cycles, waiting for the mn completion strobe.
module paper_sequencer #(
    parameter int PC_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] pc,
    input  logic [1:0]      instr_op,
    input  logic [1:0]      instr_reg,
    input  logic [PC_W-1:0] instr_target,
    output logic [1:0]      instruct,
    output logic [1:0]      reg_sel,
    output logic            pulser,
    input  logic            mn,
    input  logic            reg_zero,
    output logic            busy,
    output logic            halted,
    output logic            timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_JNO = 2'b10;
    localparam logic [1:0] OP_STP = 2'b11;
    localparam logic [7:0] TMO    = 8'(TIMEOUT);

    state_t          state, state_n;
    logic [PC_W-1:0] pc_n, target, target_n, pc_inc;
    logic [1:0]      instruct_n, reg_sel_n;
    logic [7:0]      wait_cnt, wait_cnt_n, wait_cnt_inc;
    logic            mn_q, first_wait, first_wait_n, timeout_err_n;

    assign pc_inc       = pc + PC_W'(1);
    assign wait_cnt_inc = wait_cnt + 8'd1;
    assign busy         = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
    assign halted       = (state == S_HALT);

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instruct_n    = instruct;
        reg_sel_n     = reg_sel;
        target_n      = target;
        wait_cnt_n    = wait_cnt;
        first_wait_n  = first_wait;
        timeout_err_n = timeout_err;
        pulser        = 1'b0;
        case (state)
            S_IDLE: begin
                pc_n = '0;
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                instruct_n = instr_op;
                reg_sel_n  = instr_reg;
                target_n   = instr_target;
                state_n    = S_ISSUE;
            end
            S_ISSUE: begin
                case (instruct)
                    OP_INC, OP_DEC: begin
                        pulser       = 1'b1;
                        wait_cnt_n   = '0;
                        first_wait_n = 1'b1;
                        state_n      = S_WAIT;
                    end
                    OP_JNO: begin
                        pc_n    = reg_zero ? pc_inc : target;
                        state_n = S_FETCH;
                    end
                    OP_STP: state_n = S_HALT;
                    default: state_n = S_HALT;
                endcase
            end
            S_WAIT: begin
                first_wait_n = 1'b0;
                // A level held over from the previous instruction still counts on the first cycle.
                if (mn && (first_wait || !mn_q)) begin
                    pc_n    = pc_inc;
                    state_n = S_FETCH;
                end else if (wait_cnt_inc == TMO) begin
                    timeout_err_n = 1'b1;
                    state_n       = S_HALT;
                end else begin
                    wait_cnt_n = wait_cnt_inc;
                end
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruct    <= 2'b00;
            reg_sel     <= 2'b00;
            target      <= '0;
            wait_cnt    <= '0;
            first_wait  <= 1'b0;
            mn_q        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instruct    <= instruct_n;
            reg_sel     <= reg_sel_n;
            target      <= target_n;
            wait_cnt    <= wait_cnt_n;
            first_wait  <= first_wait_n;
            mn_q        <= mn;
            timeout_err <= timeout_err_n;
        end
    end

endmodule

// File: tb/tb_paper_sequencer.sv
// Directed bench for paper_sequencer: program memory model, mn responder, cycle and pulse counters.
module tb_paper_sequencer;

    localparam int PC_W = 4;

    logic            clk = 1'b0;
    logic            rst, start, mn, reg_zero;
    logic [PC_W-1:0] pc, instr_target;
    logic [1:0]      instr_op, instr_reg, instruct, reg_sel;
    logic            pulser, busy, halted, timeout_err;

    logic [1:0]      op_mem  [16];
    logic [1:0]      reg_mem [16];
    logic [PC_W-1:0] tgt_mem [16];

    int checks = 0;
    int errors = 0;
    int mn_delay = 0;
    logic mn_hold = 1'b0;
    int cd = 0;
    int pulse_cnt = 0;
    int busy_cyc = 0;
    logic [1:0] last_instruct, last_reg;

    always #5 clk = ~clk;

    assign instr_op     = op_mem[pc];
    assign instr_reg    = reg_mem[pc];
    assign instr_target = tgt_mem[pc];

    paper_sequencer #(.PC_W(PC_W), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .instr_op(instr_op), .instr_reg(instr_reg), .instr_target(instr_target),
        .instruct(instruct), .reg_sel(reg_sel), .pulser(pulser),
        .mn(mn), .reg_zero(reg_zero), .busy(busy), .halted(halted),
        .timeout_err(timeout_err)
    );

    // Execution unit model: returns mn mn_delay cycles after pulser (0 = never), or holds it.
    initial begin
        mn = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) busy_cyc++;
            mn = mn_hold;
            if (cd > 0) begin
                cd--;
                if (cd == 0) mn = 1'b1;
            end
            if (pulser) begin
                pulse_cnt++;
                last_instruct = instruct;
                last_reg      = reg_sel;
                cd            = mn_delay;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            op_mem[i]  = 2'b11;
            reg_mem[i] = 2'b00;
            tgt_mem[i] = '0;
        end
    endtask

    task automatic put(input int a, input logic [1:0] op, input logic [1:0] r, input logic [PC_W-1:0] t);
        op_mem[a]  = op;
        reg_mem[a] = r;
        tgt_mem[a] = t;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic launch(input int delay);
        mn_delay  = delay;
        pulse_cnt = 0;
        busy_cyc  = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (halted) break;
            @(negedge clk);
        end
        check(tag, halted, 1);
    endtask

    task automatic wait_pulses(input int n);
        for (int i = 0; i < 100; i++) begin
            if (pulse_cnt >= n) break;
            @(negedge clk);
        end
        check("pulse_reach", pulse_cnt >= n, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; reg_zero = 1'b0;
        clear_prog();
        do_reset();
        @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_pulser", pulser, 0);
        check("rst_instruct", instruct, 0);

        // Spurious mn in IDLE
        mn_hold = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_mn_busy", busy, 0);
        check("idle_mn_pc", pc, 0);
        mn_hold = 1'b0;
        @(negedge clk);

        // INC r1; STP, mn two cycles after pulser
        clear_prog();
        put(0, 2'b00, 2'b01, 4'd0);
        launch(2);
        wait_halt("inc_halt");
        check("inc_pulses", pulse_cnt, 1);
        check("inc_instruct", last_instruct, 2'b00);
        check("inc_reg", last_reg, 2'b01);
        check("inc_pc", pc, 1);
        check("inc_cycles", busy_cyc, 6);
        check("inc_terr", timeout_err, 0);

        // HALT ignores start
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("halt_sticky", halted, 1);
        check("halt_busy", busy, 0);

        // JNO taken: 0 -> 5
        do_reset();
        clear_prog();
        reg_zero = 1'b0;
        put(0, 2'b10, 2'b10, 4'd5);
        launch(0);
        wait_halt("jno_t_halt");
        check("jno_t_pc", pc, 5);
        check("jno_t_pulses", pulse_cnt, 0);
        check("jno_t_cycles", busy_cyc, 4);

        // JNO not taken: 0 -> 1
        do_reset();
        reg_zero = 1'b1;
        launch(0);
        wait_halt("jno_n_halt");
        check("jno_n_pc", pc, 1);
        check("jno_n_pulses", pulse_cnt, 0);

        // DEC never acknowledged -> timeout after 15 WAIT cycles
        do_reset();
        clear_prog();
        put(0, 2'b01, 2'b00, 4'd0);
        launch(0);
        wait_halt("tmo_halt");
        check("tmo_err", timeout_err, 1);
        check("tmo_pc", pc, 0);
        check("tmo_cycles", busy_cyc, 17);
        check("tmo_instruct", last_instruct, 2'b01);

        // Jump to 15, INC there wraps pc to 0, then JNO falls through to STP at 1
        do_reset();
        clear_prog();
        reg_zero = 1'b0;
        put(0, 2'b10, 2'b00, 4'd15);
        put(15, 2'b00, 2'b10, 4'd0);
        launch(1);
        wait_pulses(1);
        reg_zero = 1'b1;
        wait_halt("wrap_halt");
        check("wrap_pc", pc, 1);
        check("wrap_cycles", busy_cyc, 9);
        check("wrap_reg", last_reg, 2'b10);

        // mn held high across two INCs: each completes on its first WAIT cycle
        do_reset();
        clear_prog();
        put(0, 2'b00, 2'b01, 4'd0);
        put(1, 2'b00, 2'b10, 4'd0);
        mn_hold = 1'b1;
        launch(0);
        wait_halt("hold_halt");
        mn_hold = 1'b0;
        check("hold_pulses", pulse_cnt, 2);
        check("hold_pc", pc, 2);
        check("hold_cycles", busy_cyc, 8);
        check("hold_terr", timeout_err, 0);

        // Reset mid-WAIT with start also high, then restart
        do_reset();
        clear_prog();
        put(0, 2'b01, 2'b11, 4'd0);
        launch(0);
        wait_pulses(1);
        repeat (3) @(negedge clk);
        check("midwait_busy", busy, 1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_pc", pc, 0);
        check("mrst_instruct", instruct, 0);
        check("mrst_reg", reg_sel, 0);
        check("mrst_pulser", pulser, 0);
        check("mrst_halted", halted, 0);
        check("mrst_terr", timeout_err, 0);
        put(0, 2'b00, 2'b01, 4'd0);
        launch(1);
        wait_halt("restart_halt");
        check("restart_pc", pc, 1);
        check("restart_cycles", busy_cyc, 5);
        check("restart_pulses", pulse_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paper_sequencer.md
PAPER_SEQUENCER -- requirements
Module: paper_sequencer

Interface
REQ-001 Parameter: PC_W, 4, program-counter and jump-target width.
REQ-002 Parameter: TIMEOUT, 15, max cycles to wait for mn after a pulser, 1..255.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock, sole clock domain.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  level; begins execution from address 0 when sampled high in IDLE.
REQ-007 pc  out  PC_W  program memory address, combinational read.
REQ-008 instr_op  in  2  opcode at pc: 00 INC, 01 DEC, 10 JNO, 11 STP.
REQ-009 instr_reg  in  2  register select at pc.
REQ-010 instr_target  in  PC_W  JNO jump target at pc.
REQ-011 instruct  out  2  registered opcode driven to execution units.
REQ-012 reg_sel  out  2  registered register select driven to execution units.
REQ-013 pulser  out  1  one-cycle issue strobe to the execution unit.
REQ-014 mn  in  1  completion strobe from the execution unit; any width of 1 or more cycles.
REQ-015 reg_zero  in  1  selected register currently holds 0, valid while reg_sel is stable.
REQ-016 busy  out  1  high in FETCH, ISSUE, WAIT.
REQ-017 halted  out  1  high in HALT.
REQ-018 timeout_err  out  1  sticky; set when the mn wait expires.

Function
REQ-019 States: IDLE, FETCH, ISSUE, WAIT, HALT; one-hot or binary encoding is free.
REQ-020 IDLE: pc held at 0; start=1 -> FETCH next cycle.
REQ-021 FETCH: latch instr_op to instruct and instr_reg to reg_sel, latch instr_target internally, then go to ISSUE.
REQ-022 ISSUE, INC or DEC: drive pulser=1 for exactly this cycle, clear the wait counter, then go to WAIT.
REQ-023 ISSUE, JNO: pulser stays 0; reg_zero=0 -> pc<=target; reg_zero=1 -> pc<=pc+1; then go to FETCH.
REQ-024 ISSUE, STP: pulser stays 0; pc unchanged; go to HALT.
REQ-025 WAIT: mn is edge-detected. The first cycle mn is high after being low, or mn high in the first WAIT cycle, gives pc<=pc+1 and a return to FETCH.
REQ-026 WAIT: the counter increments each cycle without mn. When the counter reaches TIMEOUT: set timeout_err, go to HALT, leave pc unchanged.
REQ-027 mn while not in WAIT: ignored, with no state change.
REQ-028 pc arithmetic: modulo 2^PC_W; pc=2^PC_W-1 increments to 0 without a flag.
REQ-029 HALT: leave only by rst; start is ignored.
REQ-030 Minimum instruction time: JNO 2 cycles; INC/DEC with mn on the first WAIT cycle 3 cycles.
REQ-031 instruct and reg_sel stay stable from FETCH until the next FETCH.
REQ-032 pulser is never high in two consecutive cycles.

Reset
REQ-033 rst=1 at any clock edge, in any state including mid-WAIT, gives: state IDLE, pc=0, instruct=00, reg_sel=00, pulser=0, busy=0, halted=0, timeout_err=0, wait counter=0, mn edge history=0.
REQ-034 rst takes priority over start, mn and every state transition in the same cycle.

Verification
REQ-035 Program {0: INC r1, 1: STP}; start; mn returned 2 cycles after pulser -> one pulser with instruct=00 reg_sel=01; halted=1; pc=1.
REQ-036 Program {0: JNO r2 ->5, 5: STP}; reg_zero=0 -> pc sequence 0,5; no pulser; halted. Repeat with reg_zero=1 -> pc 0,1.
REQ-037 Program {0: DEC r0}; never return mn -> after TIMEOUT=15 WAIT cycles, timeout_err=1, halted=1, pc=0.
REQ-038 PC_W=4; jump to 15; INC at 15 acknowledged -> pc wraps to 0.
REQ-039 Hold mn high continuously across two INCs -> the second INC completes on its first WAIT cycle. Spurious mn in IDLE -> no effect.
REQ-040 Assert rst in WAIT, then start -> all outputs at reset values, then execution restarts at pc=0.
